rf_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback requesters
//  (ALU result path, memory/load path) using round-robin valid/ready arbitration.

---
 rtl/rf_wb_arbiter.sv | 108 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port between the ALU and memory writeback paths, and sequences a soft-clear sweep.
// Optional RF_WB_DROP_R0_EN: a requester write to address 0 still handshakes, but it never reaches the port.
module rf_wb_arbiter #(
  parameter int unsigned          ADDR_W    = 5,
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          NREGS     = 32,
  parameter logic [DATA_W-1:0]    CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] wrAdd,
  output logic [DATA_W-1:0] wrData,
  output logic              wrEnable
);

  typedef enum logic {ST_ARB, ST_CLEAR} state_t;
  typedef enum logic {RR_ALU, RR_MEM} rr_t;

  state_t              state_q;
  rr_t                 rr_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                clr_done_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_add_q;
  logic [DATA_W-1:0]   wr_data_q;

  logic                xfer;
  logic                wr_en_d;
  logic [ADDR_W-1:0]   wr_add_d;
  logic [DATA_W-1:0]   wr_data_d;

  // clr_req wins the cycle it is seen, so no requester is accepted alongside it.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (state_q == ST_ARB && !clr_req) begin
      alu_ready = alu_valid && (!mem_valid || rr_q == RR_ALU);
      mem_ready = mem_valid && (!alu_valid || rr_q == RR_MEM);
    end
    xfer      = alu_ready || mem_ready;
    wr_add_d  = alu_ready ? alu_addr : mem_addr;
    wr_data_d = alu_ready ? alu_data : mem_data;
`ifdef RF_WB_DROP_R0_EN
    wr_en_d   = xfer && (wr_add_d != '0);
`else
    wr_en_d   = xfer;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ARB;
      rr_q       <= RR_ALU;
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_add_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      clr_done_q <= 1'b0;
      wr_en_q    <= 1'b0;
      case (state_q)
        ST_ARB: begin
          if (clr_req) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
          end else if (xfer) begin
            wr_en_q   <= wr_en_d;
            wr_add_q  <= wr_add_d;
            wr_data_q <= wr_data_d;
            rr_q      <= alu_ready ? RR_MEM : RR_ALU;
          end
        end
        ST_CLEAR: begin
          wr_en_q   <= 1'b1;
          wr_add_q  <= clr_cnt_q;
          wr_data_q <= CLR_VALUE;
          if (clr_cnt_q == ADDR_W'(NREGS - 1)) begin
            clr_done_q <= 1'b1;
            clr_cnt_q  <= '0;
            state_q    <= ST_ARB;
          end else begin
            clr_cnt_q  <= clr_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = clr_done_q;
  assign wrEnable = wr_en_q;
  assign wrAdd    = wr_add_q;
  assign wrData   = wr_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and random checks of rf_wb_arbiter against a behavioural model.
module tb_rf_wb_arbiter;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 32;
  localparam logic [DATA_W-1:0] CLRV = '0;

  logic clk = 1'b0, rst = 1'b1, clr_req = 1'b0;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic [ADDR_W-1:0] alu_addr = '0, mem_addr = '0;
  logic [DATA_W-1:0] alu_data = '0, mem_data = '0;
  logic clr_busy, clr_done, alu_ready, mem_ready, wrEnable;
  logic [ADDR_W-1:0] wrAdd;
  logic [DATA_W-1:0] wrData;

  rf_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS), .CLR_VALUE(CLRV)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wrAdd(wrAdd), .wrData(wrData), .wrEnable(wrEnable));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Model: who was granted last, and how much of the clear sweep is still left.
  bit  m_ptr_mem;
  bit  m_clr;
  int  m_idx;
  logic                e_en, e_done;
  logic [ADDR_W-1:0]   e_addr;
  logic [DATA_W-1:0]   e_data;
  bit  m_ga, m_gm;
  logic obs_ar, obs_mr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr_mem = 0; m_clr = 0; m_idx = 0;
    e_en = 0; e_done = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0; clr_req = 1'b0;
    #1;
    chk("rst_wrEnable", 64'(wrEnable), 64'd0);
    chk("rst_wrAdd",    64'(wrAdd),    64'd0);
    chk("rst_wrData",   64'(wrData),   64'd0);
    chk("rst_clr_busy", 64'(clr_busy), 64'd0);
    chk("rst_clr_done", 64'(clr_done), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic cycle();
    bit drop;
    #1;
    m_ga = 0; m_gm = 0;
    if (!m_clr && !clr_req) begin
      if (alu_valid && (!mem_valid || !m_ptr_mem)) m_ga = 1;
      else if (mem_valid) m_gm = 1;
    end
    obs_ar = alu_ready; obs_mr = mem_ready;
    chk("alu_ready", 64'(alu_ready), 64'(m_ga));
    chk("mem_ready", 64'(mem_ready), 64'(m_gm));
    chk("clr_busy_pre", 64'(clr_busy), 64'(m_clr));
    e_done = 0;
    if (m_clr) begin
      e_en = 1; e_addr = ADDR_W'(m_idx); e_data = CLRV;
      e_done = (m_idx == NREGS - 1);
      m_idx++;
      if (m_idx == NREGS) begin m_clr = 0; m_idx = 0; end
    end else if (clr_req) begin
      m_clr = 1; m_idx = 0; e_en = 0;
    end else if (m_ga || m_gm) begin
      e_addr = m_ga ? alu_addr : mem_addr;
      e_data = m_ga ? alu_data : mem_data;
`ifdef RF_WB_DROP_R0_EN
      drop = (e_addr == 0);
`else
      drop = 0;
`endif
      e_en = !drop;
      m_ptr_mem = m_ga;
    end else begin
      e_en = 0;
    end
    @(posedge clk); #1;
    chk("wrEnable", 64'(wrEnable), 64'(e_en));
    chk("wrAdd",    64'(wrAdd),    64'(e_addr));
    chk("wrData",   64'(wrData),   64'(e_data));
    chk("clr_done", 64'(clr_done), 64'(e_done));
    chk("clr_busy", 64'(clr_busy), 64'(m_clr));
  endtask

  initial begin
    int done_cnt;
    logic [ADDR_W-1:0] done_addr;
    model_reset();
    // Test 1: async reset asserted mid-cycle
    @(posedge clk);
    do_reset();

    // Test 3: both valid held, alternating grants starting with ALU
    alu_valid = 1; alu_addr = 5'd1; alu_data = 32'h1111_0001;
    mem_valid = 1; mem_addr = 5'd2; mem_data = 32'h2222_0002;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t3_alu_grant", 64'(obs_ar), 64'((k % 2) == 0));
      chk("t3_mem_grant", 64'(obs_mr), 64'((k % 2) == 1));
      chk("t3_port_addr", 64'(wrAdd),  64'(((k % 2) == 0) ? 1 : 2));
    end
    alu_valid = 0; mem_valid = 0;
    cycle();

    // Test 2: single ALU write, one-cycle latency
    alu_valid = 1; alu_addr = 5'd3; alu_data = 32'hDEADBEEF;
    cycle();
    chk("t2_ready", 64'(obs_ar), 64'd1);
    chk("t2_en",    64'(wrEnable), 64'd1);
    chk("t2_addr",  64'(wrAdd), 64'd3);
    chk("t2_data",  64'(wrData), 64'hDEADBEEF);
    alu_valid = 0;
    cycle();
    chk("t2_idle_en", 64'(wrEnable), 64'd0);

    // Test 4: clear with both valid pending; clr_req held into CLEAR is ignored
    alu_valid = 1; alu_addr = 5'd7; alu_data = 32'hA5A5_0007;
    mem_valid = 1; mem_addr = 5'd9; mem_data = 32'h5A5A_0009;
    clr_req = 1;
    done_cnt = 0; done_addr = '0;
    cycle();
    for (int k = 0; k < NREGS; k++) begin
      if (k == 3) clr_req = 0;
      cycle();
      if (clr_done) begin done_cnt++; done_addr = wrAdd; end
    end
    chk("t4_done_cnt",  64'(done_cnt), 64'd1);
    chk("t4_done_addr", 64'(done_addr), 64'd31);
    cycle();
    chk("t4_resume_mem", 64'(obs_mr), 64'd1);
    alu_valid = 0; mem_valid = 0;

    // Test 5: reset during the sweep, then a fresh clear starts at addr 0
    clr_req = 1; cycle(); clr_req = 0;
    for (int k = 0; k < 10; k++) cycle();
    do_reset();
    clr_req = 1; cycle(); clr_req = 0;
    cycle();
    chk("t5_restart_addr", 64'(wrAdd), 64'd0);
    for (int k = 1; k < NREGS; k++) cycle();

    // Test 6: write to register 0
    mem_valid = 1; mem_addr = '0; mem_data = 32'h0BAD_F00D;
    cycle();
    chk("t6_ready", 64'(obs_mr), 64'd1);
    mem_valid = 0;
    cycle();

    // Random traffic: requesters hold addr/data until accepted
    for (int n = 0; n < 3000; n++) begin
      if (!alu_valid || m_ga) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_addr  = ADDR_W'($urandom);
        alu_data  = $urandom;
      end
      if (!mem_valid || m_gm) begin
        mem_valid = ($urandom_range(0, 3) != 0);
        mem_addr  = ADDR_W'($urandom);
        mem_data  = $urandom;
      end
      clr_req = ($urandom_range(0, 79) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
